// File: rtl/cache_line_xfer.sv
// Line-transfer engine: moves whole cache lines between the data RAM and the bus
// as single Avalon bursts (writeback: RAM -> bus, refill: bus -> RAM).
module cache_line_xfer #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned BC_W       = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  ram_addr,
  output logic              ram_rd,
  input  logic [31:0]       ram_rdata,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  output logic [31:0]       m_address,
  output logic [3:0]        m_byteEnable,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writeData,
  input  logic              m_waitRequest,
  output logic              m_beginBurstTransfer,
  output logic [BC_W-1:0]   m_burstCount,
  input  logic [31:0]       m_readData,
  input  logic              m_readDataValid
);

  typedef enum logic [2:0] {
    StIdle,
    StWbLoad,
    StWbBurst,
    StRfCmd,
    StRfData,
    StDone
  } state_t;

  localparam logic [IDX_W:0]  Words = (IDX_W + 1)'(LINE_WORDS);
  localparam logic [IDX_W:0]  Last  = (IDX_W + 1)'(LINE_WORDS - 1);
  localparam logic [IDX_W:0]  One   = (IDX_W + 1)'(1);
  localparam logic [BC_W-1:0] Bc    = BC_W'(LINE_WORDS);

  state_t           state;
  logic [31:0]      base;
  logic [IDX_W:0]   beat;
  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] rd_addr;
  logic [31:0]      line_buf [LINE_WORDS];

  logic [31:0]      aligned_addr;
  logic [IDX_W:0]   nidx;
  logic [IDX_W:0]   nbeat;
  logic [IDX_W-1:0] prev_idx;
  logic             rf_beat_wr;
  logic             unused_addr_bits;

  assign aligned_addr     = {req_addr[31:IDX_W+2], {(IDX_W + 2){1'b0}}};
  assign unused_addr_bits = ^req_addr[IDX_W+1:0];
  assign nidx             = idx + One;
  assign nbeat            = beat + One;
  assign prev_idx         = idx[IDX_W-1:0] - IDX_W'(1);

  // Refill data goes straight from the bus into the RAM in the beat's own cycle.
  assign rf_beat_wr = (state == StRfData) && m_readDataValid;
  assign ram_wr     = rf_beat_wr;
  assign ram_wdata  = rf_beat_wr ? m_readData : 32'h0;
  assign ram_addr   = rf_beat_wr ? beat[IDX_W-1:0] : rd_addr;

  // Read data lags its strobe by one cycle, so idx=k captures word k-1.
  always_ff @(posedge clk) begin
    if (state == StWbLoad && idx != '0) begin
      line_buf[prev_idx] <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state                <= StIdle;
      base                 <= 32'h0;
      beat                 <= '0;
      idx                  <= '0;
      rd_addr              <= '0;
      req_ready            <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      ram_rd               <= 1'b0;
      m_address            <= 32'h0;
      m_byteEnable         <= 4'h0;
      m_read               <= 1'b0;
      m_write              <= 1'b0;
      m_writeData          <= 32'h0;
      m_beginBurstTransfer <= 1'b0;
      m_burstCount         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            base      <= aligned_addr;
            beat      <= '0;
            idx       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_write) begin
              state   <= StWbLoad;
              ram_rd  <= 1'b1;
              rd_addr <= '0;
            end else begin
              state                <= StRfCmd;
              m_read               <= 1'b1;
              m_address            <= aligned_addr;
              m_burstCount         <= Bc;
              m_byteEnable         <= 4'hF;
              m_beginBurstTransfer <= 1'b1;
            end
          end
        end

        StWbLoad: begin
          if (idx == Words) begin
            // Final word lands in line_buf this edge; word 0 has long been stable.
            state                <= StWbBurst;
            m_write              <= 1'b1;
            m_address            <= base;
            m_burstCount         <= Bc;
            m_byteEnable         <= 4'hF;
            m_beginBurstTransfer <= 1'b1;
            m_writeData          <= line_buf[0];
          end else begin
            idx <= nidx;
            if (nidx == Words) begin
              ram_rd  <= 1'b0;
              rd_addr <= '0;
            end else begin
              ram_rd  <= 1'b1;
              rd_addr <= nidx[IDX_W-1:0];
            end
          end
        end

        StWbBurst: begin
          if (!m_waitRequest) begin
            if (beat == Last) begin
              state                <= StDone;
              done                 <= 1'b1;
              m_write              <= 1'b0;
              m_address            <= 32'h0;
              m_burstCount         <= '0;
              m_byteEnable         <= 4'h0;
              m_beginBurstTransfer <= 1'b0;
              m_writeData          <= 32'h0;
            end else begin
              beat                 <= nbeat;
              m_writeData          <= line_buf[nbeat[IDX_W-1:0]];
              m_beginBurstTransfer <= 1'b0;
            end
          end
        end

        StRfCmd: begin
          if (!m_waitRequest) begin
            state                <= StRfData;
            m_read               <= 1'b0;
            m_address            <= 32'h0;
            m_burstCount         <= '0;
            m_byteEnable         <= 4'h0;
            m_beginBurstTransfer <= 1'b0;
          end
        end

        StRfData: begin
          if (m_readDataValid) begin
            beat <= nbeat;
            if (beat == Last) begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end

        StDone: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer: table vectors, hand-written corner
// sequences and random transfers against a transaction-level reference model.
module tb_cache_line_xfer;

  localparam int LW = 8;
  localparam int IW = 3;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rest = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic          req_ready;
  logic          busy;
  logic          done;
  logic [IW-1:0] ram_addr;
  logic          ram_rd;
  logic [31:0]   ram_rdata = 32'h0;
  logic          ram_wr;
  logic [31:0]   ram_wdata;
  logic [31:0]   m_address;
  logic [3:0]    m_byteEnable;
  logic          m_read;
  logic          m_write;
  logic [31:0]   m_writeData;
  logic          m_waitRequest = 1'b0;
  logic          m_beginBurstTransfer;
  logic [BW-1:0] m_burstCount;
  logic [31:0]   m_readData = 32'h0;
  logic          m_readDataValid = 1'b0;

  int total = 0;
  int passed = 0;
  logic [31:0] ram_mem [LW];

  cache_line_xfer #(.LINE_WORDS(LW), .IDX_W(IW), .BC_W(BW)) dut (
    .clk(clk), .rest(rest), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rdata(ram_rdata), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .m_address(m_address), .m_byteEnable(m_byteEnable),
    .m_read(m_read), .m_write(m_write), .m_writeData(m_writeData),
    .m_waitRequest(m_waitRequest), .m_beginBurstTransfer(m_beginBurstTransfer),
    .m_burstCount(m_burstCount), .m_readData(m_readData),
    .m_readDataValid(m_readDataValid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   dbase;
    logic [LW-1:0] stall_mask;
    int            stall_len;
    logic [LW-1:0] gap_mask;
    int            gap_len;
    logic          stray;
    logic [31:0]   exp_base;
    int            exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: whole-transfer latency from the accept cycle to done.
  function automatic int model_latency(input logic wr, input logic [LW-1:0] stall_mask,
                                       input int stall_len, input logic [LW-1:0] gap_mask,
                                       input int gap_len);
    if (wr) return (LW + 1) + LW + 1 + stall_len * $countones(stall_mask);
    return 1 + (stall_mask[0] ? stall_len : 0) + LW + gap_len * $countones(gap_mask) + 1;
  endfunction

  function automatic logic [31:0] model_base(input logic [31:0] addr);
    return addr & ~32'((1 << (IW + 2)) - 1);
  endfunction

  // Plays RAM and bus slave for one transfer; abort_beat >= 0 asserts rest while
  // that writeback beat is pending and returns right after.
  task automatic run_xfer(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] dbase, input logic [LW-1:0] stall_mask,
                          input int stall_len, input logic [LW-1:0] gap_mask,
                          input int gap_len, input logic hold, input logic [31:0] exp_base,
                          input int exp_lat, input int abort_beat);
    int wb = 0, st = 0, rb = 0, gp = 0, nrd = 0, nwr = 0, lat = -1;
    logic cmd_done = 1'b0, prev_rd = 1'b0, aborted = 1'b0;
    logic [IW-1:0] prev_addr = '0;
    for (int k = 0; k < LW; k++)
      ram_mem[k] = wr ? dbase + 32'(k) : 32'hDEAD_0000 + 32'(k);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    m_waitRequest = 1'b0; m_readDataValid = 1'b0;
    #1;
    chk({name, " req_ready at accept"}, 32'(req_ready), 32'd1);
    for (int n = 1; n <= 200 && lat < 0 && !aborted; n++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (prev_rd) ram_rdata = ram_mem[prev_addr];
      m_waitRequest = 1'b0; m_readDataValid = 1'b0; m_readData = $urandom;
      if (abort_beat >= 0 && m_write && wb == abort_beat) begin
        rest = 1'b1; aborted = 1'b1;
      end
      if (m_write) begin
        if (stall_mask[wb] && st < stall_len) begin m_waitRequest = 1'b1; st++; end
      end else if (m_read) begin
        if (stall_mask[0] && st < stall_len) begin m_waitRequest = 1'b1; st++; end
      end else if (cmd_done && rb < LW) begin
        if (gap_mask[rb] && gp < gap_len) gp++;
        else begin m_readDataValid = 1'b1; m_readData = dbase + 32'(rb); end
      end
      #1;
      if (m_write) begin
        chk({name, " m_writeData"}, m_writeData, dbase + 32'(wb));
        chk({name, " m_beginBurstTransfer"}, 32'(m_beginBurstTransfer), 32'(wb == 0));
        chk({name, " write m_address"}, m_address, exp_base);
        chk({name, " write m_burstCount"}, 32'(m_burstCount), 32'(LW));
        chk({name, " write m_byteEnable"}, 32'(m_byteEnable), 32'hF);
        if (!m_waitRequest) begin wb++; st = 0; end
      end
      if (m_read) begin
        chk({name, " read m_address"}, m_address, exp_base);
        chk({name, " read m_beginBurstTransfer"}, 32'(m_beginBurstTransfer), 32'd1);
        chk({name, " read m_burstCount"}, 32'(m_burstCount), 32'(LW));
        if (!m_waitRequest) cmd_done = 1'b1;
      end
      chk({name, " ram_wr"}, 32'(ram_wr), 32'(m_readDataValid));
      if (m_readDataValid) begin
        chk({name, " refill ram_addr"}, 32'(ram_addr), 32'(rb));
        chk({name, " refill ram_wdata"}, ram_wdata, dbase + 32'(rb));
        rb++; gp = 0;
      end
      if (ram_wr) begin ram_mem[ram_addr] = ram_wdata; nwr++; end
      if (ram_rd) begin
        chk({name, " load ram_addr"}, 32'(ram_addr), 32'(nrd));
        nrd++;
      end
      prev_rd = ram_rd; prev_addr = ram_addr;
      chk({name, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        lat = n;
        chk({name, " req_ready in DONE"}, 32'(req_ready), 32'd0);
      end
    end
    if (abort_beat < 0) begin
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " beats"}, 32'(wr ? wb : rb), 32'(LW));
      chk({name, " ram reads"}, 32'(nrd), wr ? 32'(LW) : 32'd0);
      chk({name, " ram writes"}, 32'(nwr), wr ? 32'd0 : 32'(LW));
      if (!wr)
        for (int k = 0; k < LW; k++)
          chk({name, " ram content"}, ram_mem[k], dbase + 32'(k));
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1234, 32'h0000_00A0, 8'h00, 0, 8'h00, 0, 1'b0,
                32'h0000_1220, 10};
    vecs[1] = '{1'b1, 32'h8000_0047, 32'h0000_0010, 8'h21, 2, 8'h00, 0, 1'b0,
                32'h8000_0040, 22};
    vecs[2] = '{1'b0, 32'h0000_ABFF, 32'h0000_5500, 8'h00, 0, 8'h10, 3, 1'b1,
                32'h0000_ABE0, 13};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hC0DE_0000, 8'h00, 0, 8'h00, 0, 1'b0,
                32'hFFFF_FFE0, 18};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h0000_7700, 8'h01, 3, 8'h81, 1, 1'b0,
                32'h0000_0040, 15};
    vecs[5] = '{1'b1, 32'h1234_567F, 32'h0000_0000, 8'h80, 1, 8'h00, 0, 1'b0,
                32'h1234_5660, 19};

    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset strobes", {27'h0, m_read, m_write, m_beginBurstTransfer, ram_rd, ram_wr}, 32'h0);
    chk("reset m_burstCount", 32'(m_burstCount), 32'd0);
    chk("reset m_address", m_address, 32'h0);
    chk("reset m_byteEnable", 32'(m_byteEnable), 32'h0);
    rest = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].stray) begin
        @(negedge clk);
        m_readDataValid = 1'b1; m_readData = 32'hBAD0_BAD0;
        #1;
        chk("stray valid in IDLE ram_wr", 32'(ram_wr), 32'd0);
      end
      run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].dbase,
               vecs[i].stall_mask, vecs[i].stall_len, vecs[i].gap_mask, vecs[i].gap_len,
               1'b0, vecs[i].exp_base, vecs[i].exp_lat, -1);
    end

    // Reset while writeback beat 4 is pending.
    run_xfer("abort", 1'b1, 32'h2000_0100, 32'h0000_3300, 8'h00, 0, 8'h00, 0, 1'b0,
             32'h2000_0100, 0, 4);
    @(negedge clk);
    rest = 1'b0;
    #1;
    chk("abort m_write", 32'(m_write), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort no late done", 32'(done), 32'd0);
    end
    run_xfer("after_abort", 1'b0, 32'h0000_0F00, 32'h0000_4400, 8'h00, 0, 8'h00, 0, 1'b0,
             32'h0000_0F00, 10, -1);

    // req_valid held across DONE: next request only taken in the following IDLE cycle.
    run_xfer("b2b_first", 1'b0, 32'h0000_0200, 32'h0000_1100, 8'h00, 0, 8'h00, 0, 1'b1,
             32'h0000_0200, 10, -1);
    run_xfer("b2b_second", 1'b0, 32'h0000_0300, 32'h0000_2200, 8'h00, 0, 8'h00, 0, 1'b0,
             32'h0000_0300, 10, -1);

    for (int i = 0; i < 24; i++) begin
      logic          wr;
      logic [31:0]   addr, dbase;
      logic [LW-1:0] sm, gm;
      int            sl, gl;
      wr = 1'($urandom_range(0, 1));
      addr = $urandom; dbase = $urandom;
      sm = LW'($urandom); gm = LW'($urandom);
      sl = int'($urandom_range(0, 3)); gl = int'($urandom_range(0, 3));
      run_xfer($sformatf("rnd%0d", i), wr, addr, dbase, sm, sl, gm, gl, 1'b0,
               model_base(addr), model_latency(wr, sm, sl, gm, gl), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
